// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
//   Iterative radix-2 restoring integer divider with RV64M semantics
//   (DIV / DIVU / REM / REMU and their 32-bit W forms). Quotient and remainder
//   are produced together, one quotient bit per cycle. Divide-by-zero and
//   signed overflow are resolved in a single cycle without iterating.
//
// Ports
//   clock       in   1     rising-edge clock
//   reset       in   1     asynchronous, active-low reset
//   in_valid    in   1     request valid, taken only while out_ready=1
//   flush       in   1     cancels an in-flight or same-cycle request
//   divw        in   1     1: 32-bit op on low halves, results sign-extended
//   div_signed  in   1     1: signed (DIV/REM), 0: unsigned (DIVU/REMU)
//   dividend    in   XLEN  dividend
//   divisor     in   XLEN  divisor
//   out_ready   out  1     1 = idle, can accept a request
//   out_valid   out  1     single-cycle pulse, results valid
//   quotient    out  XLEN  quotient, 0 while out_valid=0
//   remainder   out  XLEN  remainder, 0 while out_valid=0
// -----------------------------------------------------------------------------
module divider #(
   parameter int XLEN = 64
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   input  logic            flush,
   input  logic            divw,
   input  logic            div_signed,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            out_ready,
   output logic            out_valid,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   localparam int HALF = XLEN / 2;
   localparam int CW   = $clog2(XLEN);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_reg;
   state_t state_next;

   // Datapath registers
   logic [XLEN-1:0] rem_reg;      // partial remainder
   logic [XLEN-1:0] quo_reg;      // dividend shifting out / quotient shifting in
   logic [XLEN-1:0] dv_abs_reg;   // |divisor|
   logic [CW-1:0]   count_reg;    // step counter, 0..N-1
   logic [CW-1:0]   last_reg;     // N-1 for the accepted operation
   logic            q_neg_reg;
   logic            r_neg_reg;
   logic            divw_reg;

   // ---------------------------------------------------------------------------
   // Operand preprocessing (combinational, used only in the accept cycle)
   // ---------------------------------------------------------------------------
   logic            accept;
   logic [XLEN-1:0] dd_ext;
   logic [XLEN-1:0] dv_ext;
   logic            dd_neg;
   logic            dv_neg;
   logic [XLEN-1:0] dd_abs;
   logic [XLEN-1:0] dv_abs;
   logic [XLEN-1:0] min_val;
   logic            div_zero;
   logic            overflow;
   logic            special;

   assign accept = in_valid & (state_reg == IDLE) & ~flush;

   always_comb begin
      if (divw) begin
         dd_ext = div_signed ? {{HALF{dividend[HALF-1]}}, dividend[HALF-1:0]}
                             : {{HALF{1'b0}}, dividend[HALF-1:0]};
         dv_ext = div_signed ? {{HALF{divisor[HALF-1]}}, divisor[HALF-1:0]}
                             : {{HALF{1'b0}}, divisor[HALF-1:0]};
      end else begin
         dd_ext = dividend;
         dv_ext = divisor;
      end
   end

   assign dd_neg = div_signed & dd_ext[XLEN-1];
   assign dv_neg = div_signed & dv_ext[XLEN-1];
   assign dd_abs = dd_neg ? (~dd_ext + 1'b1) : dd_ext;
   assign dv_abs = dv_neg ? (~dv_ext + 1'b1) : dv_ext;

   // Most negative value of the active width, as it appears after extension.
   // For the W form this is 0xFFFF_FFFF_8000_0000 (sign-extended 32-bit MIN).
   assign min_val = divw ? {{(HALF + 1){1'b1}}, {(HALF - 1){1'b0}}}
                         : {1'b1, {(XLEN - 1){1'b0}}};

   assign div_zero = (dv_ext == '0);
   assign overflow = div_signed & (dd_ext == min_val) & (dv_ext == '1);
   assign special  = div_zero | overflow;

   // ---------------------------------------------------------------------------
   // One restoring step: shift {rem,quo} left, try subtracting |divisor|.
   // The trial is one bit wider so its MSB is the borrow (negative result).
   // ---------------------------------------------------------------------------
   logic [XLEN:0]   shifted;
   logic [XLEN:0]   trial;
   logic            q_bit;
   logic [XLEN-1:0] step_rem;
   logic [XLEN-1:0] step_quo;

   always_comb begin
      shifted  = {rem_reg, quo_reg[XLEN-1]};
      trial    = shifted - {1'b0, dv_abs_reg};
      q_bit    = ~trial[XLEN];
      step_rem = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
      step_quo = {quo_reg[XLEN-2:0], q_bit};
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      if (flush) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  state_next = special ? DONE : BUSY;
               end
            end
            BUSY: begin
               if (count_reg == last_reg) begin
                  state_next = DONE;
               end
            end
            DONE: begin
               state_next = IDLE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rem_reg    <= '0;
         quo_reg    <= '0;
         dv_abs_reg <= '0;
         count_reg  <= '0;
         last_reg   <= '0;
         q_neg_reg  <= 1'b0;
         r_neg_reg  <= 1'b0;
         divw_reg   <= 1'b0;
      end else if (accept) begin
         divw_reg   <= divw;
         count_reg  <= '0;
         last_reg   <= divw ? CW'(HALF - 1) : CW'(XLEN - 1);
         dv_abs_reg <= dv_abs;
         if (div_zero) begin
            // Final results are loaded directly; no sign fix-up in DONE.
            quo_reg   <= '1;
            rem_reg   <= dd_ext;
            q_neg_reg <= 1'b0;
            r_neg_reg <= 1'b0;
         end else if (overflow) begin
            quo_reg   <= dd_ext;
            rem_reg   <= '0;
            q_neg_reg <= 1'b0;
            r_neg_reg <= 1'b0;
         end else begin
            rem_reg   <= '0;
            // W form: left-align the 32-bit magnitude so only HALF steps are
            // needed; the zeros behind it become the zero-extended quotient.
            quo_reg   <= divw ? {dd_abs[HALF-1:0], {HALF{1'b0}}} : dd_abs;
            q_neg_reg <= dd_neg ^ dv_neg;
            r_neg_reg <= dd_neg;
         end
      end else if (state_reg == BUSY) begin
         rem_reg   <= step_rem;
         quo_reg   <= step_quo;
         count_reg <= count_reg + CW'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs, including sign fix-up and W-form sign extension
   // ---------------------------------------------------------------------------
   logic [XLEN-1:0] q_fix;
   logic [XLEN-1:0] r_fix;
   logic [XLEN-1:0] q_final;
   logic [XLEN-1:0] r_final;

   always_comb begin
      q_fix   = q_neg_reg ? (~quo_reg + 1'b1) : quo_reg;
      r_fix   = r_neg_reg ? (~rem_reg + 1'b1) : rem_reg;
      q_final = divw_reg ? {{HALF{q_fix[HALF-1]}}, q_fix[HALF-1:0]} : q_fix;
      r_final = divw_reg ? {{HALF{r_fix[HALF-1]}}, r_fix[HALF-1:0]} : r_fix;

      out_ready = (state_reg == IDLE);
      out_valid = (state_reg == DONE) & ~flush;
      quotient  = out_valid ? q_final : '0;
      remainder = out_valid ? r_final : '0;
   end

endmodule

// File: tb/tb_divider.sv
module tb_divider;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        flush;
   logic        divw;
   logic        div_signed;
   logic [63:0] dividend;
   logic [63:0] divisor;
   logic        out_ready;
   logic        out_valid;
   logic [63:0] quotient;
   logic [63:0] remainder;

   int checks = 0;
   int errors = 0;

   // Scoreboard: expected results pushed when a request is driven
   logic [63:0] exp_q[$];
   logic [63:0] exp_r[$];
   int          exp_lat[$];

   divider #(.XLEN(64)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .flush      (flush),
      .divw       (divw),
      .div_signed (div_signed),
      .dividend   (dividend),
      .divisor    (divisor),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .quotient   (quotient),
      .remainder  (remainder)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Independent reference model built on the language's own / and %.
   task automatic ref_div(input logic w, input logic s, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] q, output logic [63:0] r, output int lat);
      logic signed [31:0] a32, b32;
      logic signed [63:0] a64, b64;
      logic [31:0] q32, r32;
      if (w) begin
         a32 = a[31:0];
         b32 = b[31:0];
         if (b32 == 0) begin
            q32 = 32'hFFFF_FFFF; r32 = a32; lat = 1;
         end else if (s && a32 == 32'sh8000_0000 && b32 == -1) begin
            q32 = a32; r32 = 32'h0; lat = 1;
         end else begin
            lat = 33;
            if (s) begin
               q32 = a32 / b32; r32 = a32 % b32;
            end else begin
               q32 = $unsigned(a32) / $unsigned(b32); r32 = $unsigned(a32) % $unsigned(b32);
            end
         end
         q = {{32{q32[31]}}, q32};
         r = {{32{r32[31]}}, r32};
      end else begin
         a64 = a;
         b64 = b;
         if (b64 == 0) begin
            q = '1; r = a; lat = 1;
         end else if (s && a64 == 64'sh8000_0000_0000_0000 && b64 == -1) begin
            q = a; r = 64'h0; lat = 1;
         end else begin
            lat = 65;
            if (s) begin
               q = a64 / b64; r = a64 % b64;
            end else begin
               q = $unsigned(a64) / $unsigned(b64); r = $unsigned(a64) % $unsigned(b64);
            end
         end
      end
   endtask

   // Drive one request, keep in_valid high with junk while busy (must be
   // ignored), wait for the result and compare against the scoreboard.
   task automatic run_op(input string tag, input logic w, input logic s,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] eq, input logic [63:0] er, input int lat);
      int   cyc;
      bit   seen;
      logic [63:0] q_e, r_e;
      int   l_e;
      @(negedge clock);
      in_valid = 1'b1; divw = w; div_signed = s; dividend = a; divisor = b;
      exp_q.push_back(eq); exp_r.push_back(er); exp_lat.push_back(lat);
      @(posedge clock);
      @(negedge clock);
      dividend = {$urandom, $urandom}; divisor = {$urandom, $urandom}; divw = ~w;
      cyc = 1;
      seen = 0;
      if (lat > 1) begin
         check({tag, " busy_ready"}, {63'd0, out_ready}, 64'd0);
         check({tag, " idle_quotient"}, quotient, 64'd0);
      end
      while (cyc <= 200) begin
         if (out_valid) begin
            seen = 1;
            break;
         end
         @(negedge clock);
         cyc++;
      end
      in_valid = 1'b0;
      q_e = exp_q.pop_front();
      r_e = exp_r.pop_front();
      l_e = exp_lat.pop_front();
      check({tag, " valid_seen"}, {63'd0, seen}, 64'd1);
      if (seen) begin
         check({tag, " latency"}, 64'(cyc), 64'(l_e));
         check({tag, " quotient"}, quotient, q_e);
         check({tag, " remainder"}, remainder, r_e);
         $display("op %s: w=%0d s=%0d a=%h b=%h -> q=%h r=%h at cycle %0d",
                  tag, w, s, a, b, quotient, remainder, cyc);
         @(negedge clock);
         check({tag, " pulse_end"}, {63'd0, out_valid}, 64'd0);
         check({tag, " ready_after"}, {63'd0, out_ready}, 64'd1);
      end
   endtask

   task automatic count_pulses(input int n, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         if (out_valid) pulses++;
      end
   endtask

   function automatic logic [63:0] pick_operand();
      logic [63:0] v;
      case ($urandom_range(0, 7))
         0: v = 64'd0;
         1: v = '1;
         2: v = 64'h8000_0000_0000_0000;
         3: v = 64'($urandom_range(0, 20));
         4: v = 64'hFFFF_FFFF_8000_0000;
         5: v = {$urandom, $urandom} >> $urandom_range(0, 63);
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   initial begin
      int          pulses;
      logic        w, s;
      logic [63:0] a, b, q, r;
      int          lat;

      reset = 1'b0; in_valid = 1'b0; flush = 1'b0; divw = 1'b0; div_signed = 1'b0;
      dividend = '0; divisor = '0;
      repeat (3) @(negedge clock);
      check("reset out_ready", {63'd0, out_ready}, 64'd1);
      check("reset out_valid", {63'd0, out_valid}, 64'd0);
      check("reset quotient", quotient, 64'd0);
      check("reset remainder", remainder, 64'd0);
      reset = 1'b1;

      // Directed cases with hand-computed results
      run_op("T1_100div7", 0, 0, 64'd100, 64'd7, 64'd14, 64'd2, 65);
      run_op("T2_m7div2", 0, 1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65);
      run_op("T2_7divm2", 0, 1, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65);
      run_op("T3_div0_s", 0, 1, 64'd42, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd42, 1);
      run_op("T3_div0_u", 0, 0, 64'd42, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd42, 1);
      run_op("T4_ovf64", 0, 1, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 64'd0, 1);
      run_op("T4_ovfw", 1, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
             64'hFFFF_FFFF_8000_0000, 64'd0, 1);
      run_op("T5_divuw", 1, 0, 64'h0000_0001_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 64'd0, 33);
      run_op("T5_divuw1", 1, 0, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 33);
      run_op("divw_neg", 1, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD,
             64'hFFFF_FFFF_FFFF_FFFF, 33);
      run_op("divuw0", 1, 0, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000,
             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 1);
      run_op("u64_big", 0, 0, '1, 64'd3, 64'h5555_5555_5555_5555, 64'd0, 65);

      // Flush in BUSY cycle 10: cancelled, no pulse
      @(negedge clock);
      in_valid = 1'b1; divw = 1'b0; div_signed = 1'b0; dividend = 64'd12345; divisor = 64'd7;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      for (int i = 1; i < 10; i++) @(negedge clock);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      check("flush_busy ready", {63'd0, out_ready}, 64'd1);
      count_pulses(80, pulses);
      check("flush_busy pulses", 64'(pulses), 64'd0);
      $display("op flush_busy: pulses=%0d", pulses);
      run_op("T6_1000div10", 0, 0, 64'd1000, 64'd10, 64'd100, 64'd0, 65);

      // Flush together with in_valid: not accepted
      @(negedge clock);
      in_valid = 1'b1; flush = 1'b1; divw = 1'b0; div_signed = 1'b0; dividend = 64'd5; divisor = 64'd1;
      @(negedge clock);
      in_valid = 1'b0; flush = 1'b0;
      check("flush_accept ready", {63'd0, out_ready}, 64'd1);
      count_pulses(70, pulses);
      check("flush_accept pulses", 64'(pulses), 64'd0);
      $display("op flush_accept: pulses=%0d", pulses);

      // Flush in the DONE cycle suppresses out_valid combinationally
      @(negedge clock);
      in_valid = 1'b1; divw = 1'b0; div_signed = 1'b0; dividend = 64'd42; divisor = 64'd0;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      check("flush_done pre_valid", {63'd0, out_valid}, 64'd1);
      flush = 1'b1;
      #1;
      check("flush_done valid", {63'd0, out_valid}, 64'd0);
      check("flush_done quotient", quotient, 64'd0);
      @(negedge clock);
      flush = 1'b0;
      check("flush_done ready", {63'd0, out_ready}, 64'd1);
      $display("op flush_done: valid suppressed");

      // Reset at cycle 20 of an operation
      @(negedge clock);
      in_valid = 1'b1; divw = 1'b0; div_signed = 1'b1; dividend = 64'd99999; divisor = 64'd13;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      for (int i = 1; i < 20; i++) @(negedge clock);
      reset = 1'b0;
      #1;
      check("reset_mid ready", {63'd0, out_ready}, 64'd1);
      check("reset_mid valid", {63'd0, out_valid}, 64'd0);
      check("reset_mid quotient", quotient, 64'd0);
      check("reset_mid remainder", remainder, 64'd0);
      @(negedge clock);
      reset = 1'b1;
      count_pulses(80, pulses);
      check("reset_mid pulses", 64'(pulses), 64'd0);
      $display("op reset_mid: pulses=%0d", pulses);

      // Randomised operations against the reference model
      for (int n = 0; n < 250; n++) begin
         w = 1'($urandom_range(0, 1));
         s = 1'($urandom_range(0, 1));
         a = pick_operand();
         b = pick_operand();
         ref_div(w, s, a, b, q, r, lat);
         run_op($sformatf("rand%0d", n), w, s, a, b, q, r, lat);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
